// File: rtl/mac_array_acc.sv
// mac_array_acc: pipelined dot-product MAC with a persistent accumulator.
// Each accepted beat multiplies pr lanes of a and b and sums the products.
// The beat sum is folded into an accumulator framed by first/last flags.
// Pipeline: product register -> adder-tree register -> accumulator/output.
// The whole pipeline freezes while a finished result waits on out_ready.
// Optional feature: define MAC_ARRAY_ACC_SATURATE_EN so the accumulator
// clamps on overflow instead of wrapping.
module mac_array_acc #(
   parameter int bw      = 8,
   parameter int pr      = 16,
   parameter int bw_psum = 2*bw+8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [pr*bw-1:0]    a,
   input  logic [pr*bw-1:0]    b,
   input  logic                is_signed,
   input  logic                first,
   input  logic                last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [bw_psum-1:0]  out
);

   localparam int pw = 2*bw;               // product width
   localparam int sw = 2*bw + $clog2(pr);  // adder-tree sum width

   // The pipeline moves only when the output register is free or being drained.
   logic advance;
   logic out_valid_q;
   logic [bw_psum-1:0] out_q;

   assign advance   = !(out_valid_q && !out_ready);
   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign out       = out_q;

   // ---------------- Stage 1: lane products ----------------
   logic [pw-1:0] prod_d [pr];
   logic [pw-1:0] prod_q [pr];
   logic          s1_valid_q, s1_signed_q, s1_first_q, s1_last_q;

   for (genvar gi = 0; gi < pr; gi++) begin : g_lane
      logic [pw-1:0] a_ext, b_ext;
      // Extend each operand to the full product width before multiplying
      assign a_ext = is_signed ? {{bw{a[bw*(gi+1)-1]}}, a[bw*gi +: bw]}
                               : {{bw{1'b0}}, a[bw*gi +: bw]};
      assign b_ext = is_signed ? {{bw{b[bw*(gi+1)-1]}}, b[bw*gi +: bw]}
                               : {{bw{1'b0}}, b[bw*gi +: bw]};
      // Low pw bits of the extended product are exact for both signednesses
      assign prod_d[gi] = a_ext * b_ext;
   end

   // Stage-1 control: valid and per-beat flags
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_signed_q <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
      end else if (advance) begin
         s1_valid_q  <= in_valid;
         s1_signed_q <= is_signed;
         s1_first_q  <= first;
         s1_last_q   <= last;
      end
   end

   // Stage-1 data: product register, no reset needed (qualified by valid)
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int k = 0; k < pr; k++) begin
            prod_q[k] <= prod_d[k];
         end
      end
   end

   // ---------------- Stage 2: adder tree ----------------
   logic [sw-1:0] sum_d;
   logic [sw-1:0] s2_sum_q;
   logic          s2_valid_q, s2_signed_q, s2_first_q, s2_last_q;

   // Sum all lane products; width is large enough that nothing overflows
   always_comb begin
      sum_d = '0;
      for (int k = 0; k < pr; k++) begin
         if (s1_signed_q) begin
            sum_d = sum_d + {{(sw-pw){prod_q[k][pw-1]}}, prod_q[k]};
         end else begin
            sum_d = sum_d + {{(sw-pw){1'b0}}, prod_q[k]};
         end
      end
   end

   // Stage-2 register: beat sum plus flags
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid_q  <= 1'b0;
         s2_signed_q <= 1'b0;
         s2_first_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_sum_q    <= '0;
      end else if (advance) begin
         s2_valid_q  <= s1_valid_q;
         s2_signed_q <= s1_signed_q;
         s2_first_q  <= s1_first_q;
         s2_last_q   <= s1_last_q;
         s2_sum_q    <= sum_d;
      end
   end

   // ---------------- Stage 3: accumulator ----------------
   logic [bw_psum-1:0] sum_ext;
   logic [bw_psum-1:0] add_d;
   logic [bw_psum-1:0] acc_d;
   logic [bw_psum-1:0] acc_q;

   if (bw_psum > sw) begin : g_ext
      assign sum_ext = s2_signed_q ? {{(bw_psum-sw){s2_sum_q[sw-1]}}, s2_sum_q}
                                   : {{(bw_psum-sw){1'b0}}, s2_sum_q};
   end else begin : g_noext
      assign sum_ext = s2_sum_q;
   end

`ifdef MAC_ARRAY_ACC_SATURATE_EN
   logic [bw_psum:0] acc_wide, sum_wide, add_wide;

   // One-bit-wider addition, clamped to the range of the current beat's type
   always_comb begin
      acc_wide = s2_signed_q ? {acc_q[bw_psum-1], acc_q} : {1'b0, acc_q};
      sum_wide = s2_signed_q ? {sum_ext[bw_psum-1], sum_ext} : {1'b0, sum_ext};
      add_wide = acc_wide + sum_wide;
      add_d    = add_wide[bw_psum-1:0];
      if (s2_signed_q) begin
         if (add_wide[bw_psum] != add_wide[bw_psum-1]) begin
            add_d = add_wide[bw_psum] ? {1'b1, {(bw_psum-1){1'b0}}}
                                      : {1'b0, {(bw_psum-1){1'b1}}};
         end
      end else if (add_wide[bw_psum]) begin
         add_d = {bw_psum{1'b1}};
      end
   end
`else
   // Plain modulo-2^bw_psum accumulation
   always_comb begin
      add_d = acc_q + sum_ext;
   end
`endif

   // First beat of a frame loads the sum; later beats add onto the running total
   always_comb begin
      acc_d = s2_first_q ? sum_ext : add_d;
   end

   // Accumulator and output register with its valid/ready handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (advance && s2_valid_q) begin
            acc_q <= acc_d;
         end
         if (advance && s2_valid_q && s2_last_q) begin
            out_q       <= acc_d;
            out_valid_q <= 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mac_array_acc.sv
// Testbench for mac_array_acc: table-driven directed vectors, hand-written
// reset and back-pressure sequences, and a randomized run against a
// behavioural dot-product/accumulator model.
module tb_mac_array_acc;

   localparam int BW  = 8;
   localparam int PR  = 16;
   localparam int BWP = 24;
   localparam longint MOD = 64'h1000000;

`ifdef MAC_ARRAY_ACC_SATURATE_EN
   localparam logic [23:0] OVF_EXP  = 24'h7FFFFF;
   localparam logic [23:0] OVF_NEXT = 24'h80000F;
`else
   localparam logic [23:0] OVF_EXP  = 24'h800000;
   localparam logic [23:0] OVF_NEXT = 24'h800010;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [PR*BW-1:0]  a = '0;
   logic [PR*BW-1:0]  b = '0;
   logic              is_signed = 1'b0;
   logic              first = 1'b0;
   logic              last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [BWP-1:0]    out;

   int checks = 0;
   int errors = 0;

   longint model_acc = 0;
   longint exp_q[$];

   mac_array_acc #(.bw(BW), .pr(PR), .bw_psum(BWP)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .is_signed(is_signed), .first(first), .last(last),
      .out_valid(out_valid), .out_ready(out_ready), .out(out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          n;
      logic [7:0]  av;
      logic [7:0]  bv;
      bit          sg;
      bit          f;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Dot product of one beat, straight from the arithmetic definition
   function automatic longint beat_sum(input logic [PR*BW-1:0] av, input logic [PR*BW-1:0] bv,
                                       input bit sg);
      longint s = 0;
      for (int k = 0; k < PR; k++) begin
         longint x, y;
         if (sg) begin
            x = longint'($signed(av[k*BW +: BW]));
            y = longint'($signed(bv[k*BW +: BW]));
         end else begin
            x = longint'(av[k*BW +: BW]);
            y = longint'(bv[k*BW +: BW]);
         end
         s += x * y;
      end
      return s;
   endfunction

   // Reference accumulator update for one accepted beat
   task automatic model_accept(input logic [PR*BW-1:0] av, input logic [PR*BW-1:0] bv,
                               input bit sg, input bit f, input bit l);
      longint s, base, t;
      s = beat_sum(av, bv, sg);
`ifdef MAC_ARRAY_ACC_SATURATE_EN
      if (f) base = 0;
      else if (sg) base = (model_acc >= MOD/2) ? model_acc - MOD : model_acc;
      else base = model_acc;
      t = base + s;
      if (sg) begin
         if (t > MOD/2 - 1) t = MOD/2 - 1;
         if (t < -(MOD/2)) t = -(MOD/2);
      end else if (t > MOD - 1) begin
         t = MOD - 1;
      end
`else
      base = f ? 0 : model_acc;
      t = base + s;
`endif
      model_acc = t & (MOD - 1);
      if (l) exp_q.push_back(model_acc);
   endtask

   // One clock cycle under the scoreboard: inputs are already driven
   task automatic cycle();
      @(negedge clk);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0h required=none", out);
         end else begin
            longint e;
            e = exp_q.pop_front();
            chk("sb_result", 64'(out), e);
            $display("result out=%06h expected=%06h", out, e[23:0]);
         end
      end
      if (in_valid && in_ready) model_accept(a, b, is_signed, first, last);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      first = 1'b0;
      last = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      model_acc = 0;
      exp_q.delete();
   endtask

   task automatic rand_inputs(input bit fl_both);
      for (int k = 0; k < PR; k++) begin
         a[k*BW +: BW] = BW'($urandom);
         b[k*BW +: BW] = BW'($urandom);
      end
      is_signed = 1'($urandom);
      if (fl_both) begin
         first = 1'b1;
         last  = 1'b1;
      end else begin
         first = ($urandom_range(0, 9) < 3);
         last  = ($urandom_range(0, 9) < 3);
      end
   endtask

   // n beats of uniform lanes, first on beat 0 (if f), last on the final beat;
   // checks the result appears exactly 3 cycles after the last beat
   task automatic run_seq(input string name, input int n, input logic [7:0] av,
                          input logic [7:0] bv, input bit sg, input bit f,
                          input logic [23:0] exp);
      for (int j = 0; j < n; j++) begin
         in_valid  = 1'b1;
         a         = {PR{av}};
         b         = {PR{bv}};
         is_signed = sg;
         first     = f && (j == 0);
         last      = (j == n - 1);
         if (j == 0) chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
         chk({name, "_no_early_valid"}, 64'(out_valid), 64'd0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      first = 1'b0;
      last = 1'b0;
      chk({name, "_valid_t1"}, 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk({name, "_valid_t2"}, 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk({name, "_valid_t3"}, 64'(out_valid), 64'd1);
      chk({name, "_out"}, 64'(out), 64'(exp));
      $display("vec %s out=%06h expected=%06h", name, out, exp);
      @(posedge clk);
      #1;
      chk({name, "_single_result"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [BWP-1:0] hold_val;
      int guard;

      vecs[0] = '{"neg_small",   1, 8'h03, 8'hFE, 1'b1, 1'b1, 24'hFFFFA0};
      vecs[1] = '{"continue",    1, 8'h01, 8'h01, 1'b1, 1'b0, 24'hFFFFB0};
      vecs[2] = '{"four_beats",  4, 8'h7F, 8'h7F, 1'b1, 1'b1, 24'h0FC040};
      vecs[3] = '{"ff_unsigned", 1, 8'hFF, 8'hFF, 1'b0, 1'b1, 24'h0FE010};
      vecs[4] = '{"ff_signed",   1, 8'hFF, 8'hFF, 1'b1, 1'b1, 24'h000010};
      vecs[5] = '{"mixed_sign",  1, 8'h80, 8'h7F, 1'b1, 1'b1, 24'hFC0800};
      vecs[6] = '{"overflow",   32, 8'h80, 8'h80, 1'b1, 1'b1, OVF_EXP};
      vecs[7] = '{"retain_zero", 1, 8'h00, 8'h00, 1'b0, 1'b0, OVF_EXP};
      vecs[8] = '{"retain_uns",  1, 8'h01, 8'h01, 1'b0, 1'b0, OVF_NEXT};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out", 64'(out), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      // Directed table
      for (int i = 0; i < 9; i++) begin
         run_seq(vecs[i].name, vecs[i].n, vecs[i].av, vecs[i].bv,
                 vecs[i].sg, vecs[i].f, vecs[i].exp);
      end

      // Reset mid-operation: two beats in flight are discarded
      in_valid = 1'b1;
      a = {PR{8'h05}};
      b = {PR{8'h05}};
      is_signed = 1'b1;
      first = 1'b1;
      last = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midreset_out_valid", 64'(out_valid), 64'd0);
      chk("midreset_out", 64'(out), 64'd0);
      chk("midreset_in_ready", 64'(in_ready), 64'd1);
      run_seq("after_reset", 1, 8'h01, 8'h01, 1'b1, 1'b1, 24'h000010);

      // Back-pressure: stall the output for 5 cycles while beats keep coming
      do_reset();
      out_ready = 1'b0;
      guard = 0;
      while (!out_valid && guard < 10) begin
         in_valid = 1'b1;
         rand_inputs(1'b1);
         cycle();
         guard++;
      end
      chk("bp_valid_reached", 64'(out_valid), 64'd1);
      hold_val = out;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         rand_inputs(1'b1);
         chk("bp_in_ready_low", 64'(in_ready), 64'd0);
         chk("bp_out_valid_held", 64'(out_valid), 64'd1);
         chk("bp_out_stable", 64'(out), 64'(hold_val));
         cycle();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
         cycle();
         guard++;
      end
      chk("bp_drained", 64'(exp_q.size()), 64'd0);

      // Randomized traffic with random back-pressure
      do_reset();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 9) < 7);
         rand_inputs(1'b0);
         cycle();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while ((exp_q.size() != 0 || out_valid) && guard < 50) begin
         cycle();
         guard++;
      end
      chk("rand_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_array_acc.md
Name: mac_array_acc

Overview:
- Parametrised, pipelined signed/unsigned dot-product MAC with a persistent accumulator and valid/ready handshakes.
- Each accepted beat multiplies pr lanes of a by b element-wise and sums the products in an adder-tree stage.
- The beat sum is added into an accumulator spanning a multi-beat dot product delimited by first/last flags.
- Sits between the activation/weight feed logic and psum storage; successor to the fixed 16-lane, non-accumulating MAC.

Parameters:
- bw, 8, lane operand width in bits.
- pr, 16, parallel lanes per beat (any value >= 2).
- bw_psum, 2*bw+8, accumulator/output width; must be >= 2*bw+$clog2(pr).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  beat on a/b/flags is valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  pr*bw  lane k at [bw*(k+1)-1 : bw*k].
- b  input  pr*bw  same packing as a.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled per beat.
- first  input  1  beat starts a new accumulation (accumulator loads the beat sum instead of adding).
- last  input  1  beat ends an accumulation; produces a result.
- out_valid  output  1  out holds a finished accumulation.
- out_ready  input  1  consumer takes out.
- out  output  bw_psum  accumulated result.

Behaviour:
- Reset: out_valid=0, out=0, accumulator=0, all stage valids=0; in_ready=1 on the first cycle after reset.
- Handshake rules:
  - advance = !(out_valid && !out_ready); in_ready = advance.
  - A beat is accepted when in_valid && in_ready.
  - When advance=0, every stage holds its contents.
- Stage 1 (product register):
  - Lane operands are extended to 2*bw bits: sign-extended if is_signed, else zero-extended.
  - Registers pr products of 2*bw bits, plus valid, is_signed, first, last.
- Stage 2 (adder tree):
  - Sum of all lanes, width 2*bw+$clog2(pr), no overflow possible.
  - Registered along with valid, is_signed, first, last.
- Stage 3 (accumulator):
  - The stage-2 sum is extended to bw_psum: sign-extended if signed, zero-extended otherwise.
  - If first, acc = sum; else acc = acc + sum.
  - If last, the same clock edge loads out with the new acc value and sets out_valid=1.
- Latency: a last beat accepted at cycle T gives out_valid=1 at T+3, with no stalls.
- out_valid clears on out_valid && out_ready, unless a new last result loads on the same edge, in which case it stays 1 with the new out.
- Throughput: one beat per cycle while advance=1.
- Boundary cases:
  - first && last on the same beat: out = that beat's sum alone.
  - Beat without first after a result: continues accumulating onto the retained acc.
  - Beat with in_valid=0: inserts a bubble; acc unchanged.
  - Overflow: acc wraps modulo 2^bw_psum.
  - is_signed change mid-accumulation: allowed and applied per beat; no error flagged.
  - Reset mid-operation: all in-flight beats are discarded and acc=0; no out_valid follows from pre-reset beats.

Optional Feature:
- Macro: MAC_ARRAY_ACC_SATURATE_EN.
- Defined:
  - The stage-3 addition is computed one bit wider.
  - On overflow, acc clamps to the maximum/minimum of bw_psum: signed range when the current beat is_signed, unsigned maximum 2^bw_psum-1 otherwise.
  - Clamped values are stored and output.
- Undefined: plain wrap-around addition, no extra logic.

Test Plan:
- Single beat, signed, bw=8, pr=16, all a=3, all b=-2, first=last=1 -> out_valid at T+3, out=24'hFFFFA0 (-96).
- Four back-to-back signed beats, a=127, b=127, first on beat 0, last on beat 3 -> exactly one result, out=24'h0FC040 (1032256), at 3 cycles after the last beat.
- Data a=8'hFF, b=8'hFF, first=last: is_signed=0 -> out=24'h0FE010 (1040400); is_signed=1 -> out=24'h000010 (16).
- Back-pressure: out_ready=0 for 5 cycles after out_valid while in_valid stays 1 -> out stable, in_ready=0, no beat lost; after release the next result equals the reference-model sum.
- Overflow: 32 signed beats a=-128, b=-128, first on beat 0 only, last on beat 31 -> with MAC_ARRAY_ACC_SATURATE_EN out=24'h7FFFFF; without it out=24'h800000.
- Reset asserted 1 cycle after 2 beats enter the pipeline, then one beat a=1, b=1, first=last -> no out_valid before that result; out=16 at 3 cycles after acceptance.
